fetch_ctrl: RTL

- Fetch-side controller that drives the PC register's control inputs (load, PCsrc, target).
- Fetches one instruction per PC value from instruction memory over a valid/ready request plus valid-only response interface.
- Presents fetched instructions to decode with a valid/ready handshake and applies branch/jump redirects from execute.
- One outstanding memory request at a time. The PC register resets to 0 and, when loaded, computes PC+4 (PCsrc=0) or PC+target (PCsrc=1).

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 48 ++++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller: datapath width, FSM encoding
// and the sequential PC increment.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of every fetch-side signal around the controller: PC register
// control, instruction-memory request/response, decode handshake and the
// redirect input from execute. master = controller, slave = its environment.
interface fetch_ctrl_if #(
  parameter int XLEN = fetch_pkg::XLEN
) ();

  logic [XLEN-1:0] pc;
  logic            load;
  logic            PCsrc;
  logic [XLEN-1:0] target;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] redirect_offset;

  modport master (
    input  pc,
    output load, PCsrc, target,
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc, redirect_offset
  );

  modport slave (
    output pc,
    input  load, PCsrc, target,
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc, redirect_offset
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one instruction-memory request per PC value,
// hands the returned word to decode and steers the PC register for
// sequential fetch and for branch/jump redirects. Only one request is ever
// outstanding; a redirect during the wait marks the in-flight word as dead.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         areset,
  fetch_ctrl_if.master bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;

  logic            load_c;
  logic            pcsrc_c;
  logic [XLEN-1:0] target_c;
  logic            req_valid_c;
  logic            instr_valid_c;

  // Offset that makes PC + target land on redirect_pc + redirect_offset.
  logic [XLEN-1:0] redirect_target;
  assign redirect_target = bus.redirect_pc + bus.redirect_offset - bus.pc;

  // State and output-register update.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= S_REQ;
      req_pc_q   <= '0;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next-state and PC-control decode; redirects take priority in every state.
  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    load_c        = 1'b0;
    pcsrc_c       = 1'b0;
    target_c      = '0;
    req_valid_c   = 1'b0;
    instr_valid_c = 1'b0;

    if (bus.redirect_valid) begin
      load_c   = 1'b1;
      pcsrc_c  = 1'b1;
      target_c = redirect_target;
    end

    case (state_q)
      S_REQ: begin
        req_valid_c = !bus.redirect_valid;
        if (!bus.redirect_valid && bus.imem_req_ready) begin
          // PC steps past the requested word on the accepting edge.
          load_c   = 1'b1;
          req_pc_d = bus.pc;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
        if (bus.imem_rsp_valid) begin
          if (kill_q || bus.redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = bus.imem_rsp_data;
            instr_pc_d = req_pc_q;
            state_d    = S_OUT;
          end
        end
      end
      S_OUT: begin
        instr_valid_c = 1'b1;
        if (bus.redirect_valid || bus.instr_ready) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (areset) begin
      load_c        = 1'b0;
      pcsrc_c       = 1'b0;
      target_c      = '0;
      req_valid_c   = 1'b0;
      instr_valid_c = 1'b0;
    end
  end

  assign bus.load           = load_c;
  assign bus.PCsrc          = pcsrc_c;
  assign bus.target         = target_c;
  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_addr      = bus.pc;
  assign bus.instr_valid    = instr_valid_c;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;

endmodule
